// File: rtl/hier_fanout_node.sv
// hier_fanout_node
//   Single-stage hierarchy node that fans one source stream out to NUM_CHILDREN
//   child channels. Each accepted word is parked in a hold register and then
//   either broadcast to every child (mode 0) or handed to exactly one child in
//   strict rotation (mode 1). The mode is latched per word at source accept.
//   Nodes chain: the m_* side of one node drives the s_* side of the next level.
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   mode      0 = broadcast, 1 = round-robin; sampled only on source accept
//   s_valid   source word valid
//   s_ready   node can take a word (hold register empty); registered only
//   s_data    source payload
//   m_valid   per-child valid
//   m_ready   per-child ready; ignored for children not currently valid
//   m_data    per-child payload, child i on [i*DATA_W +: DATA_W]
//   rr_ptr    next round-robin target
//   xfer_cnt  number of source words accepted (wraps)
//   busy      hold register occupied

module hier_fanout_node #(
  parameter int unsigned NUM_CHILDREN = 5,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CNT_W        = 16,
  localparam int unsigned PTR_W       = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mode,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [DATA_W-1:0]              s_data,
  output logic [NUM_CHILDREN-1:0]        m_valid,
  input  logic [NUM_CHILDREN-1:0]        m_ready,
  output logic [NUM_CHILDREN*DATA_W-1:0] m_data,
  output logic [PTR_W-1:0]               rr_ptr,
  output logic [CNT_W-1:0]               xfer_cnt,
  output logic                           busy
);

  localparam logic [PTR_W-1:0] PtrLast = PTR_W'(NUM_CHILDREN - 1);

  logic                    full_q, full_d;
  logic [DATA_W-1:0]       hold_q, hold_d;
  logic                    mode_q, mode_d;
  logic [NUM_CHILDREN-1:0] done_q, done_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    accept;
  logic [NUM_CHILDREN-1:0] rr_onehot;
  logic [NUM_CHILDREN-1:0] hs;
  logic [NUM_CHILDREN-1:0] done_or_hs;

  // Decode of the round-robin pointer into a child select.
  always_comb begin
    rr_onehot = '0;
    for (int unsigned i = 0; i < NUM_CHILDREN; i++) begin
      rr_onehot[i] = (ptr_q == PTR_W'(i));
    end
  end

  // Outputs depend on registers only, so s_ready has no path from m_ready.
  assign s_ready  = ~full_q;
  assign busy     = full_q;
  assign rr_ptr   = ptr_q;
  assign xfer_cnt = cnt_q;
  assign m_data   = {NUM_CHILDREN{hold_q}};
  assign m_valid  = !full_q ? '0 : (mode_q ? rr_onehot : ~done_q);

  assign accept     = s_valid & ~full_q;
  assign hs         = m_valid & m_ready;
  assign done_or_hs = done_q | hs;

  always_comb begin
    full_d = full_q;
    hold_d = hold_q;
    mode_d = mode_q;
    done_d = done_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;

    if (accept) begin
      full_d = 1'b1;
      hold_d = s_data;
      mode_d = mode;
      done_d = '0;
      cnt_d  = cnt_q + CNT_W'(1);
    end else if (full_q) begin
      if (mode_q) begin
        // Only the pointed-to child can be valid, so any handshake is the target's.
        if (|hs) begin
          full_d = 1'b0;
          ptr_d  = (ptr_q == PtrLast) ? '0 : ptr_q + PTR_W'(1);
        end
      end else begin
        // Broadcast completes in the cycle the last outstanding child accepts.
        if (&done_or_hs) begin
          full_d = 1'b0;
          done_d = '0;
        end else begin
          done_d = done_or_hs;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      hold_q <= '0;
      mode_q <= 1'b0;
      done_q <= '0;
      ptr_q  <= '0;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      hold_q <= hold_d;
      mode_q <= mode_d;
      done_q <= done_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hier_fanout_node.sv
// Bench for hier_fanout_node: directed scenarios plus a randomized run, all
// checked against a word-level reference model.

module tb_hier_fanout_node;

  localparam int N  = 5;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            mode, s_valid, s_ready, busy;
  logic [DW-1:0]   s_data;
  logic [N-1:0]    m_valid, m_ready;
  logic [N*DW-1:0] m_data;
  logic [2:0]      rr_ptr;
  logic [15:0]     xfer_cnt;

  // Second node with a narrow counter to exercise wrap.
  logic            c_mode = 1'b0;
  logic            c_s_valid = 1'b0;
  logic            c_s_ready, c_busy;
  logic [DW-1:0]   c_s_data = 8'h5E;
  logic [N-1:0]    c_m_valid;
  logic [N-1:0]    c_m_ready = '1;
  logic [N*DW-1:0] c_m_data;
  logic [2:0]      c_rr_ptr;
  logic [3:0]      c_xfer_cnt;

  hier_fanout_node #(.NUM_CHILDREN(N), .DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .mode(mode), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .rr_ptr(rr_ptr), .xfer_cnt(xfer_cnt), .busy(busy)
  );

  hier_fanout_node #(.NUM_CHILDREN(N), .DATA_W(DW), .CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .mode(c_mode), .s_valid(c_s_valid), .s_ready(c_s_ready),
    .s_data(c_s_data), .m_valid(c_m_valid), .m_ready(c_m_ready), .m_data(c_m_data),
    .rr_ptr(c_rr_ptr), .xfer_cnt(c_xfer_cnt), .busy(c_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: one pending word, set of children that already got it,
  // count of round-robin deliveries (target = deliveries mod N), accept count.
  bit            mdl_full;
  bit            mdl_mode;
  logic [DW-1:0] mdl_word;
  bit            mdl_got[N];
  int            mdl_rr_deliveries;
  int            mdl_accepts;

  task automatic model_reset();
    mdl_full = 0;
    mdl_mode = 0;
    mdl_word = '0;
    for (int i = 0; i < N; i++) mdl_got[i] = 0;
    mdl_rr_deliveries = 0;
    mdl_accepts = 0;
  endtask

  function automatic logic [N-1:0] exp_valid();
    logic [N-1:0] v = '0;
    if (mdl_full) begin
      if (mdl_mode) v[mdl_rr_deliveries % N] = 1'b1;
      else for (int i = 0; i < N; i++) v[i] = !mdl_got[i];
    end
    return v;
  endfunction

  // Advance the model across one rising edge with the given inputs.
  task automatic model_step(input logic sv, input logic [DW-1:0] sd, input logic md,
                            input logic [N-1:0] mr);
    logic [N-1:0] take;
    bit all_got;
    if (rst) begin
      model_reset();
    end else if (mdl_full) begin
      take = exp_valid() & mr;
      if (mdl_mode) begin
        if (take != 0) begin
          mdl_full = 0;
          mdl_rr_deliveries++;
        end
      end else begin
        for (int i = 0; i < N; i++) if (take[i]) mdl_got[i] = 1;
        all_got = 1;
        for (int i = 0; i < N; i++) if (!mdl_got[i]) all_got = 0;
        if (all_got) mdl_full = 0;
      end
    end else if (sv) begin
      mdl_full = 1;
      mdl_word = sd;
      mdl_mode = md;
      for (int i = 0; i < N; i++) mdl_got[i] = 0;
      mdl_accepts++;
    end
  endtask

  task automatic check_all();
    check_eq("s_ready", s_ready, !mdl_full);
    check_eq("busy", busy, mdl_full);
    check_eq("rr_ptr", rr_ptr, mdl_rr_deliveries % N);
    check_eq("xfer_cnt", xfer_cnt, mdl_accepts % 65536);
    check_eq("m_valid", m_valid, exp_valid());
    check_eq("m_data", m_data, {N{mdl_word}});
  endtask

  // Called just after a falling edge: drive, step model, then check at the next falling edge.
  task automatic tick(input logic sv, input logic [DW-1:0] sd, input logic md,
                      input logic [N-1:0] mr);
    s_valid = sv;
    s_data  = sd;
    mode    = md;
    m_ready = mr;
    model_step(sv, sd, md, mr);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    tick(1'b0, '0, 1'b0, '0);
    rst = 1'b0;
  endtask

  initial begin
    s_valid = 0; s_data = '0; mode = 0; m_ready = '0;
    model_reset();
    @(negedge clk);

    // Reset held with s_valid high: nothing is taken, then accept after release.
    rst = 1'b1;
    #1;
    check_all();
    check_eq("rst_s_ready", s_ready, 1);
    repeat (3) begin
      tick(1'b1, 8'h3C, 1'b0, '0);
      check_eq("rst_hold_valid", m_valid, 0);
      check_eq("rst_hold_cnt", xfer_cnt, 0);
    end
    rst = 1'b0;
    tick(1'b1, 8'h3C, 1'b0, '0);
    check_eq("rel_busy", busy, 1);
    check_eq("rel_cnt", xfer_cnt, 1);
    tick(1'b0, '0, 1'b0, '1);

    // Broadcast with all children ready: one-cycle presentation.
    do_reset();
    tick(1'b1, 8'hA5, 1'b0, '1);
    check_eq("bc_valid", m_valid, 5'b11111);
    check_eq("bc_data", m_data, {N{8'hA5}});
    tick(1'b0, '0, 1'b0, '1);
    check_eq("bc_free_valid", m_valid, 0);
    check_eq("bc_free_ready", s_ready, 1);
    check_eq("bc_cnt", xfer_cnt, 1);

    // Staggered broadcast acceptance; ready on already-served children is ignored.
    do_reset();
    tick(1'b1, 8'h5A, 1'b0, '0);
    check_eq("stag0", m_valid, 5'b11111);
    tick(1'b0, '0, 1'b0, 5'b00101);
    check_eq("stag1", m_valid, 5'b11010);
    tick(1'b0, '0, 1'b0, 5'b10000);
    check_eq("stag2", m_valid, 5'b01010);
    tick(1'b0, '0, 1'b0, 5'b10101);
    check_eq("stag3", m_valid, 5'b01010);
    tick(1'b0, '0, 1'b0, 5'b01010);
    check_eq("stag4", m_valid, 5'b00000);
    check_eq("stag_ready", s_ready, 1);

    // Round-robin rotation over seven words.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      tick(1'b1, 8'h10 + k[7:0], 1'b1, '1);
      check_eq("rr_target", m_valid, 1 << (k % 5));
      tick(1'b0, '0, 1'b1, '1);
    end
    check_eq("rr_ptr_end", rr_ptr, 2);
    check_eq("rr_cnt_end", xfer_cnt, 7);

    // Stalled round-robin target is not skipped; then reset discards the word.
    do_reset();
    tick(1'b1, 8'hC3, 1'b1, '0);
    repeat (4) begin
      tick(1'b0, '0, 1'b1, 5'b11110);
      check_eq("stall_valid", m_valid, 5'b00001);
      check_eq("stall_data", m_data[7:0], 8'hC3);
      check_eq("stall_ready", s_ready, 0);
    end
    rst = 1'b1;
    model_reset();
    #1;
    check_eq("midrst_valid", m_valid, 0);
    check_eq("midrst_busy", busy, 0);
    tick(1'b0, '0, 1'b0, '0);
    rst = 1'b0;

    // Mode change while a round-robin word is pending.
    do_reset();
    tick(1'b1, 8'h77, 1'b1, '0);
    tick(1'b0, '0, 1'b0, '0);
    check_eq("tog_pending", m_valid, 5'b00001);
    tick(1'b0, '0, 1'b0, '1);
    check_eq("tog_done", m_valid, 0);
    check_eq("tog_ptr", rr_ptr, 1);
    tick(1'b1, 8'h88, 1'b0, '0);
    check_eq("tog_bcast", m_valid, 5'b11111);
    tick(1'b0, '0, 1'b1, '1);
    check_eq("tog_ptr_kept", rr_ptr, 1);

    // Narrow counter: 17 accepts wrap to 1.
    do_reset();
    c_s_valid = 1'b1;
    repeat (34) tick(1'b0, '0, 1'b0, '0);
    c_s_valid = 1'b0;
    check_eq("cnt_wrap", c_xfer_cnt, 17 % 16);
    check_eq("cnt_wrap_idle", c_busy, 0);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      logic [N-1:0] r;
      for (int i = 0; i < N; i++) r[i] = ($urandom_range(99) < 60);
      rst = ($urandom_range(299) == 0);
      tick($urandom_range(99) < 70, DW'($urandom), $urandom_range(1) == 1, r);
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
